// File: rtl/cla_stream_accumulator.sv
// rtl/cla_stream_accumulator.sv - stream accumulator driving an external CLA adder; macro CLA_ACC_SAT_EN selects saturate-on-wrap
module cla_stream_accumulator #(
    parameter int NBIT  = 7,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBIT-1:0]  in_data,
    input  logic             in_last,
    output logic [NBIT-1:0]  add_a,
    output logic [NBIT-1:0]  add_b,
    input  logic [NBIT-1:0]  add_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBIT-1:0]  out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [NBIT-1:0]  acc;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             beat;
    logic             wrap;
    logic             release_result;
    logic [NBIT-1:0]  acc_load;

    // Operands are refused only while a finished result waits downstream.
    assign in_ready       = (state != ST_HOLD);
    assign out_valid      = (state == ST_HOLD);
    assign beat           = in_valid & in_ready;
    assign release_result = out_valid & out_ready;

    // The adder sees the running sum and the offered operand, or zero when idle.
    assign add_a = acc;
    assign add_b = in_valid ? in_data : '0;

    // An unsigned sum smaller than its accumulator input means the add wrapped.
    assign wrap = (add_s < add_a);

`ifdef CLA_ACC_SAT_EN
    assign acc_load = wrap ? '1 : add_s;
`else
    assign acc_load = add_s;
`endif

    assign out_data  = acc;
    assign out_count = count;
    assign out_ovf   = ovf;

    // Next-state decode: a last beat closes the stream, acceptance reopens it.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_ACCUM: begin
                if (beat) begin
                    state_nxt = in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Accumulator, beat counter and sticky wrap flag; cleared when the result leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (release_result) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (beat) begin
            acc   <= acc_load;
            count <= (count == '1) ? count : count + CNT_ONE;
            ovf   <= ovf | wrap;
        end
    end

endmodule

// File: tb/tb_cla_stream_accumulator.sv
// tb/tb_cla_stream_accumulator.sv - directed-vector bench for cla_stream_accumulator with a behavioural adder
module tb_cla_stream_accumulator;
    localparam int NBIT  = 7;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [NBIT-1:0]  in_data;
    logic             in_last;
    logic [NBIT-1:0]  add_a;
    logic [NBIT-1:0]  add_b;
    logic [NBIT-1:0]  add_s;
    logic             out_valid;
    logic             out_ready;
    logic [NBIT-1:0]  out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    int n_vec;
    int n_err;

    cla_stream_accumulator #(.NBIT(NBIT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_s     (add_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    // Stand-in for the CLA: modulo-2^NBIT sum.
    assign add_s = add_a + add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int data, input logic last);
        in_valid = 1'b1;
        in_data  = NBIT'(data);
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        #1;

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_count", out_count, 0);
        check("rst_out_ovf",   out_ovf,   0);
        check("rst_in_ready",  in_ready,  1);
        check("idle_add_b",    add_b,     0);

        // Stream 2,3,5(last)
        in_valid = 1'b1;
        in_data  = 7'd2;
        #1;
        check("add_b_valid", add_b, 2);
        check("add_a_first", add_a, 0);
        send(2, 1'b0);
        check("accum_out_valid", out_valid, 0);
        send(3, 1'b0);
        check("accum_add_a", add_a, 5);
        send(5, 1'b1);
        check("s1_out_valid", out_valid, 1);
        check("s1_out_data",  out_data,  10);
        check("s1_out_count", out_count, 3);
        check("s1_out_ovf",   out_ovf,   0);
        check("s1_in_ready",  in_ready,  0);
        step();
        check("s1_valid_one_cycle", out_valid, 0);
        check("s1_cleared_data",    out_data,  0);

        // Stream 124,15(last): wraps
        send(124, 1'b0);
        send(15, 1'b1);
        check("s2_out_valid", out_valid, 1);
`ifdef CLA_ACC_SAT_EN
        check("s2_out_data", out_data, 127);
`else
        check("s2_out_data", out_data, 11);
`endif
        check("s2_out_ovf",   out_ovf,   1);
        check("s2_out_count", out_count, 2);
        step();
        check("s2_ovf_cleared", out_ovf, 0);

        // Single beat 54(last) with downstream stalled, operands offered meanwhile
        out_ready = 1'b0;
        send(54, 1'b1);
        in_valid = 1'b1;
        in_data  = 7'd7;
        for (int i = 0; i < 5; i++) begin
            check("s3_in_ready",  in_ready,  0);
            check("s3_out_valid", out_valid, 1);
            check("s3_out_data",  out_data,  54);
            check("s3_out_count", out_count, 1);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("s3_released_valid", out_valid, 0);
        check("s3_idle_in_ready",  in_ready,  1);
        check("s3_idle_count",     out_count, 0);

        // Stream 16,10 aborted by reset, then 24,13(last)
        send(16, 1'b0);
        send(10, 1'b0);
        check("s4_partial", out_data, 26);
        rst_n = 1'b0;
        #1;
        check("s4_async_data",  out_data,  0);
        check("s4_async_count", out_count, 0);
        step();
        rst_n = 1'b1;
        #1;
        check("s4_post_rst_valid", out_valid, 0);
        check("s4_post_rst_ready", in_ready,  1);
        send(24, 1'b0);
        send(13, 1'b1);
        check("s4_out_valid", out_valid, 1);
        check("s4_out_data",  out_data,  37);
        check("s4_out_count", out_count, 2);
        check("s4_out_ovf",   out_ovf,   0);
        step();

        // in_valid held across HOLD with out_ready=1
        send(1, 1'b1);
        check("s5_hold_data", out_data, 1);
        in_valid = 1'b1;
        in_data  = 7'd9;
        in_last  = 1'b1;
        step();
        check("s5_no_hold_beat_valid", out_valid, 0);
        check("s5_no_hold_beat_count", out_count, 0);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("s5_new_valid", out_valid, 1);
        check("s5_new_data",  out_data,  9);
        check("s5_new_count", out_count, 1);
        step();

        // Beat counter saturates at 255
        for (int i = 0; i < 260; i++) begin
            send(0, 1'b0);
        end
        send(3, 1'b1);
        check("sat_count", out_count, 255);
        check("sat_data",  out_data,  3);
        check("sat_ovf",   out_ovf,   0);
        step();
        check("sat_released", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
